// File: rtl/sample_buffer.sv
// sample_buffer: FIFO between the chord player and the codec serializer.
// Requests one sample at a time from the chord player while space allows,
// stores the results in a circular buffer and drains one entry per codec
// request. Counts underflows (codec pop on empty FIFO) and request timeouts.
// Build option: define SAMPLE_BUFFER_UNDERFLOW_HOLD_EN to repeat the last
// output on underflow instead of outputting zero.
module sample_buffer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      new_sample_ready,
  input  logic signed [15:0]        sample_in,
  input  logic                      codec_req,
  output logic                      generate_next_sample,
  output logic signed [15:0]        sample_to_codec,
  output logic                      sample_valid,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic [7:0]                underflow_count,
  output logic [7:0]                timeout_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [AW:0]   FULL_LEVEL   = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  // Saturating increment for the 8-bit event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      sat_inc8 = value;
    end else begin
      sat_inc8 = value + 8'd1;
    end
  endfunction

  logic [1:0]               state;
  logic [1:0]               next_state;
  logic [TW-1:0]            wait_cnt;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic signed [15:0]       mem [DEPTH];
  logic                     push;
  logic                     pop;
  logic                     underflow;
  logic                     timed_out;
  logic [AW:0]              fill_next;

  // Request FSM next-state logic. A ready level that is still high while
  // idle is treated as stale and holds off the next request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if ((fill_level < FULL_LEVEL) && !new_sample_ready) begin
          next_state = REQ;
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (new_sample_ready) begin
          next_state = IDLE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Push/pop decode and the resulting occupancy. An empty FIFO never
  // bypasses a same-cycle push to the codec: that pop is an underflow.
  always_comb begin
    push      = (state == WAIT) && new_sample_ready;
    timed_out = (state == WAIT) && !new_sample_ready && (wait_cnt == TIMEOUT_LAST);
    pop       = codec_req && (fill_level != '0);
    underflow = codec_req && (fill_level == '0);
    case ({push, pop})
      2'b10:   fill_next = fill_level + (AW + 1)'(1);
      2'b01:   fill_next = fill_level - (AW + 1)'(1);
      default: fill_next = fill_level;
    endcase
  end

  // FSM state, request pulse and request timer. The pulse is registered
  // so it is high exactly while the FSM sits in REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      generate_next_sample <= 1'b0;
      wait_cnt             <= '0;
      timeout_count        <= 8'd0;
    end else begin
      state                <= next_state;
      generate_next_sample <= (next_state == REQ);
      if (state == REQ) begin
        wait_cnt <= '0;
      end else if ((state == WAIT) && !new_sample_ready && (wait_cnt != TIMEOUT_LAST)) begin
        wait_cnt <= wait_cnt + TW'(1);
      end else begin
        wait_cnt <= wait_cnt;
      end
      if (timed_out) begin
        timeout_count <= sat_inc8(timeout_count);
      end else begin
        timeout_count <= timeout_count;
      end
    end
  end

  // Sample storage; contents are only read when occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // Pointers, occupancy and the codec-side output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill_level      <= '0;
      sample_to_codec <= 16'sd0;
      sample_valid    <= 1'b0;
      underflow_count <= 8'd0;
    end else begin
      fill_level   <= fill_next;
      sample_valid <= codec_req;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + AW'(1);
        sample_to_codec <= mem[rd_ptr];
      end else if (underflow) begin
        rd_ptr <= rd_ptr;
`ifdef SAMPLE_BUFFER_UNDERFLOW_HOLD_EN
        sample_to_codec <= sample_to_codec;
`else
        sample_to_codec <= 16'sd0;
`endif
      end else begin
        rd_ptr          <= rd_ptr;
        sample_to_codec <= sample_to_codec;
      end
      if (underflow) begin
        underflow_count <= sat_inc8(underflow_count);
      end else begin
        underflow_count <= underflow_count;
      end
    end
  end

endmodule

// File: doc/sample_buffer.md
# sample_buffer

Buffers the signed 16-bit audio samples produced by the chord player and delivers them to the codec interface at the codec's own request rate. It issues one-cycle `generate_next_sample` requests to the chord player whenever buffer space allows and captures each result on `new_sample_ready`. It drains one sample per codec request pulse and records underflow and request-timeout events. It sits directly downstream of the chord player and directly upstream of the codec serializer.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 4.
- `TIMEOUT`, 1024: maximum cycles to wait for `new_sample_ready` after a request.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `new_sample_ready` input 1: chord player result valid (level).
- `sample_in` input 16 signed: chord player `sample_out`.
- `codec_req` input 1: one-cycle pulse; codec wants the next sample.
- `generate_next_sample` output 1: one-cycle request pulse to the chord player.
- `sample_to_codec` output 16 signed: registered sample presented to the codec.
- `sample_valid` output 1: one-cycle pulse, one cycle after `codec_req`.
- `fill_level` output log2(DEPTH)+1: current FIFO occupancy.
- `underflow_count` output 8: saturating count of pops on an empty FIFO.
- `timeout_count` output 8: saturating count of request timeouts.

## Operation
- Request FSM states: IDLE, REQ, WAIT.
  - IDLE → REQ when `fill_level` < DEPTH and `new_sample_ready` = 0. A stale high level never starts a request.
  - REQ asserts `generate_next_sample` for exactly one cycle, clears the timeout counter, then moves to WAIT.
  - WAIT → IDLE on the first cycle with `new_sample_ready` = 1. `sample_in` is pushed into the FIFO that cycle.
  - WAIT → IDLE when the timeout counter reaches TIMEOUT-1 without `new_sample_ready`. `timeout_count` increments, saturating at 255, and nothing is pushed.
- Only one request is outstanding at a time. Because of the IDLE gate, a push never occurs when the FIFO is full.
- FIFO: circular buffer with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH. `fill_level` ranges 0..DEPTH.
- Codec side, on a `codec_req` pulse:
  - If `fill_level` > 0: pop the head into `sample_to_codec`.
  - If `fill_level` = 0: apply the underflow behaviour (see Configuration) and increment `underflow_count`, saturating at 255.
  - In both cases, pulse `sample_valid` on the next cycle.
- Push and pop in the same cycle with a non-empty FIFO: both occur and `fill_level` is unchanged.
- Push and pop in the same cycle with an empty FIFO: the pop is an underflow (no bypass), the push is stored, and `fill_level` becomes 1.
- Samples pass through unmodified. No arithmetic is applied to the data path.

## Timing
- Reset values:
  - `generate_next_sample` = 0, `sample_to_codec` = 0, `sample_valid` = 0.
  - `fill_level` = 0, `underflow_count` = 0, `timeout_count` = 0.
  - FSM = IDLE, pointers = 0.
- Reset asserted mid-operation clears all state immediately, including any outstanding request. A `new_sample_ready` arriving after reset release is ignored until the next REQ.
- The first `generate_next_sample` pulse occurs on the second rising edge after reset release, provided `new_sample_ready` = 0.
- Minimum request period is 3 cycles (IDLE, REQ, WAIT with immediate ready).
- Latency from a push to that sample being poppable is 1 cycle.
- Latency from `codec_req` to `sample_valid` and the updated `sample_to_codec` is 1 cycle.
- `sample_to_codec` holds its value between pops.

## Configuration
- `SAMPLE_BUFFER_UNDERFLOW_HOLD_EN` defined: an underflow pop repeats the previous `sample_to_codec` value. This gives a click-free hold.
- Not defined: an underflow pop drives `sample_to_codec` = 0.
- `underflow_count` behaviour is identical in both builds.

## Test plan
- Reset, then hold `new_sample_ready` high one cycle after each request, with no `codec_req` → exactly DEPTH (16) request pulses, `fill_level` = 16, no 17th pulse.
- Fill with samples 1..16, then issue 16 `codec_req` pulses spaced 5 cycles apart → `sample_to_codec` emits 1..16 in order, each with `sample_valid` exactly 1 cycle after its request, and the FIFO refills behind the pops.
- Empty FIFO with last output -300, then one `codec_req` → `sample_to_codec` = -300 with the macro defined, 0 without; `underflow_count` = 1. After 300 underflows, `underflow_count` = 255.
- Never assert `new_sample_ready` → `timeout_count` increments every TIMEOUT+2 cycles, and `generate_next_sample` re-pulses after each timeout.
- `fill_level` = 8, push and pop in the same cycle → `fill_level` stays 8. At `fill_level` = 0, push and pop in the same cycle → underflow counted and `fill_level` = 1.
- Assert `reset` low during WAIT with `fill_level` = 5 → all outputs return to reset values asynchronously, and no push occurs from a late `new_sample_ready`.
